// File: rtl/modexp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_pkg
//  Description : Shared FSM state type and default widths for the modular
//                exponentiation controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package modexp_pkg;

  localparam int MODEXP_DATA_WIDTH = 8;
  localparam int MODEXP_EXP_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    MUL    = 3'd2,
    SQR    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/modexp_mutiplicator.sv
`default_nettype none
// ============================================================================
//  Module      : mutiplicator
//  Description : Combinational modular multiplier, p = (a * b) mod m.
//                The product is formed at full double width before reduction.
//                A zero modulus yields zero instead of an undefined remainder.
//  Revision    : 1.0 - initial release
// ============================================================================
module mutiplicator #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] p_o
);

  logic [2*WIDTH-1:0] prod_w;
  logic [2*WIDTH-1:0] mod_w;

  // Widen operands, multiply, then reduce by the modulus.
  always_comb begin
    prod_w = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    mod_w  = {{WIDTH{1'b0}}, m_i};
    if (m_i == '0) begin
      p_o = '0;
    end else begin
      p_o = WIDTH'(prod_w % mod_w);
    end
  end

endmodule
`default_nettype wire

// File: rtl/modexp_controller.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_controller
//  Description : Right-to-left square-and-multiply modular exponentiation.
//                One modular multiplication per cycle through a single shared
//                multiplier; fixed latency independent of the exponent value.
//  Revision    : 1.0 - initial release
// ============================================================================
module modexp_controller
  import modexp_pkg::*;
#(
  parameter int DATA_WIDTH = MODEXP_DATA_WIDTH,
  parameter int EXP_WIDTH  = MODEXP_EXP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [EXP_WIDTH-1:0]  exponent,
  input  logic [DATA_WIDTH-1:0] modulus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int              CNT_W    = $clog2(EXP_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXP_WIDTH);

  state_t                state_q,  state_d;
  logic [DATA_WIDTH-1:0] base_q,   base_d;
  logic [EXP_WIDTH-1:0]  exp_q,    exp_d;
  logic [DATA_WIDTH-1:0] mod_q,    mod_d;
  logic [DATA_WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  error_q,  error_d;

  logic [DATA_WIDTH-1:0] mul_a_w;
  logic [DATA_WIDTH-1:0] mul_b_w;
  logic [DATA_WIDTH-1:0] mul_p_w;
  logic [CNT_W-1:0]      cnt_dec_w;

  // Operand mux for the shared multiplier; the modulus is always mod_q.
  always_comb begin
    mul_a_w = '0;
    mul_b_w = '0;
    case (state_q)
      REDUCE: begin
        mul_a_w = base_q;
        mul_b_w = DATA_WIDTH'(1);
      end
      MUL: begin
        mul_a_w = acc_q;
        mul_b_w = base_q;
      end
      SQR: begin
        mul_a_w = base_q;
        mul_b_w = base_q;
      end
      default: begin
        mul_a_w = '0;
        mul_b_w = '0;
      end
    endcase
  end

  mutiplicator #(
    .WIDTH (DATA_WIDTH)
  ) u_mul (
    .a_i (mul_a_w),
    .b_i (mul_b_w),
    .m_i (mod_q),
    .p_o (mul_p_w)
  );

  assign cnt_dec_w = cnt_q - CNT_W'(1);

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (modulus == '0) begin
            error_d  = 1'b1;
            result_d = '0;
            state_d  = DONE;
          end else begin
            base_d  = base;
            exp_d   = exponent;
            mod_d   = modulus;
            cnt_d   = CNT_LOAD;
            error_d = 1'b0;
            state_d = REDUCE;
          end
        end
      end
      REDUCE: begin
        // Bring the base below the modulus; 1 mod 1 is 0, otherwise 1.
        base_d  = mul_p_w;
        acc_d   = (mod_q == DATA_WIDTH'(1)) ? '0 : DATA_WIDTH'(1);
        state_d = MUL;
      end
      MUL: begin
        if (exp_q[0]) begin
          acc_d = mul_p_w;
        end
        state_d = SQR;
      end
      SQR: begin
        base_d = mul_p_w;
        exp_d  = exp_q >> 1;
        cnt_d  = cnt_dec_w;
        if (cnt_dec_w == '0) begin
          // The final SQR never touches acc, so acc is the answer here and
          // result is already valid while done is high.
          result_d = acc_q;
          state_d  = DONE;
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign error  = error_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_modexp_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modexp_controller
//  Description : Scoreboard bench for modexp_controller with directed cases
//                and randomized operands against a pow-mod reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modexp_controller;

  localparam int DW = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] base = '0;
  logic [EW-1:0] exponent = '0;
  logic [DW-1:0] modulus = '0;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] result;

  typedef struct {
    logic [DW-1:0] res;
    logic          err;
    int            acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  modexp_controller #(
    .DATA_WIDTH (DW),
    .EXP_WIDTH  (EW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .result   (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: repeated multiplication, b^e mod m, with 0 for a zero modulus.
  function automatic logic [DW-1:0] ref_pow(input int unsigned b, input int unsigned e,
                                            input int unsigned m);
    longint unsigned r;
    if (m == 0) return '0;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return DW'(r);
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Wait for IDLE (unless already positioned), present one start, push expectation.
  task automatic issue(input logic [DW-1:0] b, input logic [EW-1:0] e,
                       input logic [DW-1:0] m, input bit at_negedge);
    int   guard;
    exp_t x;
    guard = 0;
    if (!at_negedge) @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    base = b;
    exponent = e;
    modulus = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    x.res = ref_pow(b, e, m);
    x.err = (m == 0);
    x.acc_cyc = cyc;
    sb_q.push_back(x);
    start = 1'b0;
    // Operands are free to change while busy.
    base = DW'($urandom);
    exponent = EW'($urandom);
    modulus = DW'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 1, 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  // done is expected in the cycle ending at edge accept+1 (error) or
  // accept+2*EW+2 (normal).
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          x = sb_q.pop_front();
          chk("result", result, x.res);
          chk("error", error, x.err);
          chk("latency", cyc - x.acc_cyc + 1, x.err ? 1 : 2 * EW + 2);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowbusy;
    int guard;
    logic [DW-1:0] m;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;

    // Directed operand sets including boundaries.
    issue(8'd3,   8'd5,   8'd7,   1'b0);
    issue(8'd2,   8'd8,   8'd13,  1'b0);
    issue(8'd10,  8'd0,   8'd7,   1'b0);
    issue(8'd200, 8'd77,  8'd1,   1'b0);
    issue(8'd5,   8'd3,   8'd0,   1'b0);
    issue(8'd255, 8'd255, 8'd255, 1'b0);
    issue(8'd0,   8'd0,   8'd5,   1'b0);
    issue(8'd250, 8'd129, 8'd251, 1'b0);
    drain();
    chk("spec_3_5_7", ref_pow(3, 5, 7), 5);

    // Start while busy is ignored; busy holds until done.
    issue(8'd3, 8'd5, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    base = 8'd2; exponent = 8'd8; modulus = 8'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lowbusy = 0;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      if (!busy) lowbusy++;
      guard++;
    end
    chk("busy_held", lowbusy, 0);
    // Start presented during DONE is ignored as well.
    base = 8'd2; exponent = 8'd8; modulus = 8'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_in_done_ignored", busy, 0);
    drain();

    // Reset mid-run: no done, outputs cleared, start honoured right after.
    issue(8'd3, 8'd5, 8'd7, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    chk("abort_result", result, 0);
    rst = 1'b0;
    issue(8'd3, 8'd5, 8'd7, 1'b1);
    drain();

    // Randomized operand sets, small moduli mixed in.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 9))
        0:       m = DW'($urandom_range(0, 1));
        1:       m = DW'($urandom_range(2, 15));
        default: m = DW'($urandom);
      endcase
      issue(DW'($urandom), EW'($urandom), m, 1'b0);
    end
    drain();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
